// File: rtl/signed_mult_arb_pkg.sv
// Shared widths, requester count and operand-bus slicing for the shared multiplier scheduler.
`ifndef SMA_SLICE
`define SMA_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package signed_mult_arb_pkg;

  localparam int DEF_A_WIDTH = 32'd8;
  localparam int DEF_B_WIDTH = 32'd8;
  localparam int DEF_NUM_REQ = 32'd4;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  localparam int DEF_ID_WIDTH = id_width(DEF_NUM_REQ);

endpackage

// File: rtl/signed_mult_arb_if.sv
// Request/response bundle between the requesters, the consumer and the shared multiplier scheduler.
interface signed_mult_arb_if
  import signed_mult_arb_pkg::*;
#(
  parameter int A_WIDTH       = DEF_A_WIDTH,
  parameter int B_WIDTH       = DEF_B_WIDTH,
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int ID_WIDTH      = DEF_ID_WIDTH,
  parameter int PRODUCT_WIDTH = A_WIDTH + B_WIDTH
) ();

  logic [NUM_REQ-1:0]         req_vld;
  logic [NUM_REQ-1:0]         req_rdy;
  logic [NUM_REQ*A_WIDTH-1:0] req_dat_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_dat_b;
  logic [NUM_REQ-1:0]         req_tc;
  logic                       rsp_vld;
  logic                       rsp_rdy;
  logic [ID_WIDTH-1:0]        rsp_id;
  logic [PRODUCT_WIDTH-1:0]   rsp_product;

  // Requesters plus response consumer.
  modport master (
    output req_vld, req_dat_a, req_dat_b, req_tc, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_id, rsp_product
  );

  // The scheduler.
  modport slave (
    input  req_vld, req_dat_a, req_dat_b, req_tc, rsp_rdy,
    output req_rdy, rsp_vld, rsp_id, rsp_product
  );

endinterface

// File: rtl/signed_mult.sv
// Combinational signed/unsigned multiplier; tc selects two's-complement interpretation of both operands.
module signed_mult #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8
) (
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  logic                       tc,
  output logic [A_WIDTH+B_WIDTH-1:0] product
);

  // One extra bit per operand lets a single signed multiply cover both modes.
  logic signed [A_WIDTH:0]           a_ext_s;
  logic signed [B_WIDTH:0]           b_ext_s;
  logic signed [A_WIDTH+B_WIDTH+1:0] full_s;
  logic [1:0]                        unused_hi_s;

  assign a_ext_s     = {tc & a[A_WIDTH-1], a};
  assign b_ext_s     = {tc & b[B_WIDTH-1], b};
  assign full_s      = a_ext_s * b_ext_s;
  assign product     = full_s[A_WIDTH+B_WIDTH-1:0];
  assign unused_hi_s = full_s[A_WIDTH+B_WIDTH+1:A_WIDTH+B_WIDTH];

endmodule

// File: rtl/signed_mult_arb_rr_arb.sv
// Round-robin one-hot arbiter: the index after last_ptr has highest priority.
module rr_arb #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req_vld,
  input  logic [ID_WIDTH-1:0] last_ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                grant_any
);

  // Scan from last_ptr+1 around the ring; the first valid requester wins.
  always_comb begin
    logic [ID_WIDTH-1:0] idx_s;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx_s     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s = ID_WIDTH'((int'(last_ptr) + k) % NUM_REQ);
      if (!grant_any && req_vld[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s;
        grant_any    = 1'b1;
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/signed_mult_arb.sv
// Shares one signed_mult among NUM_REQ requesters: round-robin grant, S1 operand
// register, combinational multiply, S2 result register driving the response channel.
module signed_mult_arb
  import signed_mult_arb_pkg::*;
#(
  parameter int A_WIDTH       = DEF_A_WIDTH,
  parameter int B_WIDTH       = DEF_B_WIDTH,
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int ID_WIDTH      = DEF_ID_WIDTH,
  parameter int PRODUCT_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  signed_mult_arb_if.slave  bus
);

  logic                       adv_s;
  logic                       accept_s;
  logic                       grant_any_s;
  logic [NUM_REQ-1:0]         grant_s;
  logic [ID_WIDTH-1:0]        grant_idx_s;
  logic [ID_WIDTH-1:0]        last_ptr_r;
  logic [A_WIDTH-1:0]         sel_a_s;
  logic [B_WIDTH-1:0]         sel_b_s;

  logic                       s1_vld_r;
  logic                       s1_tc_r;
  logic [ID_WIDTH-1:0]        s1_id_r;
  logic [A_WIDTH-1:0]         s1_a_r;
  logic [B_WIDTH-1:0]         s1_b_r;
  logic [A_WIDTH+B_WIDTH-1:0] mult_product_s;

  logic                       s2_vld_r;
  logic [ID_WIDTH-1:0]        s2_id_r;
  logic [PRODUCT_WIDTH-1:0]   s2_product_r;

  // Whole pipeline moves only when the output slot is free or being drained.
  assign adv_s    = !s2_vld_r | bus.rsp_rdy;
  assign accept_s = adv_s & grant_any_s;

  rr_arb #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arb (
    .req_vld   (bus.req_vld),
    .last_ptr  (last_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  // Ready is suppressed while held in reset so nothing appears accepted.
  assign bus.req_rdy = grant_s & {NUM_REQ{adv_s & rst_n}};
  assign sel_a_s     = `SMA_SLICE(bus.req_dat_a, int'(grant_idx_s), A_WIDTH);
  assign sel_b_s     = `SMA_SLICE(bus.req_dat_b, int'(grant_idx_s), B_WIDTH);

  // Round-robin pointer follows accepted transfers only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ptr_r <= ID_WIDTH'(NUM_REQ - 1);
    end else if (accept_s) begin
      last_ptr_r <= grant_idx_s;
    end
  end

  // S1: operand register loaded from the granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_r <= 1'b0;
      s1_tc_r  <= 1'b0;
      s1_id_r  <= '0;
      s1_a_r   <= '0;
      s1_b_r   <= '0;
    end else if (adv_s) begin
      s1_vld_r <= accept_s;
      if (accept_s) begin
        s1_tc_r <= bus.req_tc[grant_idx_s];
        s1_id_r <= grant_idx_s;
        s1_a_r  <= sel_a_s;
        s1_b_r  <= sel_b_s;
      end
    end
  end

  signed_mult #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH)
  ) u_signed_mult (
    .a       (s1_a_r),
    .b       (s1_b_r),
    .tc      (s1_tc_r),
    .product (mult_product_s)
  );

  // S2: result register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_r     <= 1'b0;
      s2_id_r      <= '0;
      s2_product_r <= '0;
    end else if (adv_s) begin
      s2_vld_r <= s1_vld_r;
      if (s1_vld_r) begin
        s2_id_r      <= s1_id_r;
        s2_product_r <= PRODUCT_WIDTH'(mult_product_s);
      end
    end
  end

  assign bus.rsp_vld     = s2_vld_r;
  assign bus.rsp_id      = s2_id_r;
  assign bus.rsp_product = s2_product_r;

endmodule
